// File: rtl/auth_pkg.sv
// Shared types and constants for the rider-authorization receiver.
// Holds the UART receiver and authorization state encodings plus command bytes.
package auth_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 4;

  localparam logic [BYTE_W-1:0] CMD_GO   = 8'h47;
  localparam logic [BYTE_W-1:0] CMD_STOP = 8'h53;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    OFF,
    PWR1,
    PWR2
  } auth_state_t;

endpackage

// File: rtl/auth_rx_uart_rx.sv
// UART 8N1 receiver: RX synchronizer, mid-bit baud timing, LSB-first shifter.
// Emits a one-cycle rx_rdy for a good stop bit, or frm_err when the stop bit is low.
module uart_rx
  import auth_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rx,
  output logic [BYTE_W-1:0] o_rx_data,
  output logic              o_rx_rdy,
  output logic              o_frm_err
);

  localparam int unsigned          CNT_W    = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0]     FULL_BIT = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0]     HALF_BIT = CNT_W'(BAUD_DIV / 2);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_W - 1);

  logic                 r_rx_meta;
  logic                 r_rx_sync;
  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [CNT_W-1:0]     r_baud_cnt;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [BYTE_W-1:0]    r_shift;
  logic [BYTE_W-1:0]    r_rx_data;
  logic                 r_rx_rdy;
  logic                 r_frm_err;

  logic w_baud_done;
  logic w_load_half;
  logic w_load_full;
  logic w_clr_bits;
  logic w_shift_en;
  logic w_rdy_set;
  logic w_err_set;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Counter reloads every expiry, so a bit period is exactly BAUD_DIV cycles.
  assign w_baud_done = (r_baud_cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_half = 1'b0;
    w_load_full = 1'b0;
    w_clr_bits  = 1'b0;
    w_shift_en  = 1'b0;
    w_rdy_set   = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rx_sync) begin
          w_state_nxt = START;
          w_load_half = 1'b1;
        end
      end
      START: begin
        if (w_baud_done) begin
          if (r_rx_sync) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DATA;
            w_load_full = 1'b1;
            w_clr_bits  = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_baud_done) begin
          w_shift_en  = 1'b1;
          w_load_full = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (w_baud_done) begin
          w_state_nxt = IDLE;
          if (r_rx_sync) begin
            w_rdy_set = 1'b1;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Baud counter, bit counter and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      if (w_load_full) begin
        r_baud_cnt <= FULL_BIT;
      end else if (w_load_half) begin
        r_baud_cnt <= HALF_BIT;
      end else if (r_baud_cnt != '0) begin
        r_baud_cnt <= r_baud_cnt - CNT_W'(1);
      end

      if (w_clr_bits) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
      end

      if (w_shift_en) begin
        r_shift <= {r_rx_sync, r_shift[BYTE_W-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_data <= '0;
      r_rx_rdy  <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_rx_rdy  <= w_rdy_set;
      r_frm_err <= w_err_set;
      if (w_rdy_set) begin
        r_rx_data <= r_shift;
      end
    end
  end

  assign o_rx_data = r_rx_data;
  assign o_rx_rdy  = r_rx_rdy;
  assign o_frm_err = r_frm_err;

endmodule

// File: rtl/auth_rx.sv
// Segway power authorization: decodes rider G/S commands from the BLE UART.
// A stop request is held off (PWR2) until the load cells report the rider is off.
module auth_rx
  import auth_pkg::*;
#(
  parameter int unsigned       BAUD_DIV     = 2604,
  parameter logic [BYTE_W-1:0] CMD_GO_VAL   = CMD_GO,
  parameter logic [BYTE_W-1:0] CMD_STOP_VAL = CMD_STOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RX,
  input  logic              rider_off,
  output logic              pwr_up,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_rdy,
  output logic              frm_err
);

  logic [BYTE_W-1:0] w_rx_data;
  logic              w_rx_rdy;
  logic              w_frm_err;
  logic              w_go;
  logic              w_stop;

  auth_state_t r_state;
  auth_state_t w_state_nxt;
  logic        r_pwr_up;

  uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_rx (
    .clk       (clk),
    .rst       (rst),
    .i_rx      (RX),
    .o_rx_data (w_rx_data),
    .o_rx_rdy  (w_rx_rdy),
    .o_frm_err (w_frm_err)
  );

  assign w_go   = w_rx_rdy && (w_rx_data == CMD_GO_VAL);
  assign w_stop = w_rx_rdy && (w_rx_data == CMD_STOP_VAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= OFF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A fresh G in PWR2 wins over rider_off arriving in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      OFF: begin
        if (w_go) begin
          w_state_nxt = PWR1;
        end
      end
      PWR1: begin
        if (w_stop) begin
          w_state_nxt = rider_off ? OFF : PWR2;
        end
      end
      PWR2: begin
        if (w_go) begin
          w_state_nxt = PWR1;
        end else if (rider_off) begin
          w_state_nxt = OFF;
        end
      end
      default: w_state_nxt = OFF;
    endcase
  end

  // pwr_up tracks the state being entered, giving one clock from rx_rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwr_up <= 1'b0;
    end else begin
      r_pwr_up <= (w_state_nxt != OFF);
    end
  end

  assign pwr_up  = r_pwr_up;
  assign rx_data = w_rx_data;
  assign rx_rdy  = w_rx_rdy;
  assign frm_err = w_frm_err;

endmodule
